// File: rtl/mcntrl_pkg.sv
// Shared types and helpers for the memory-controller refresh/channel arbiter.
package mcntrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RFC_GAP   = 2'd3
  } arb_state_e;

  localparam int RR_MAX = 16;

  // First set bit of mask at or after start, wrapping modulo n; 0 when mask is empty.
  function automatic logic [3:0] rr_winner(input logic [15:0] mask,
                                           input logic [3:0]  start,
                                           input int          n);
    logic [3:0] win;
    logic [3:0] idx;
    logic       found;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      idx = 4'((int'(start) + i) % n);
      if (i < n && !found && mask[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mcntrl_rr_select.sv
// Round-robin selector: picks the first requesting index at or after start.
module mcntrl_rr_select
  import mcntrl_pkg::*;
#(
  parameter int NUM_CHN = 4,
  parameter int IDX_W   = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1
) (
  input  logic [NUM_CHN-1:0] mask,
  input  logic [IDX_W-1:0]   start,
  output logic               valid,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_CHN-1:0] onehot
);

  logic [15:0] mask_ext;
  logic [3:0]  start_ext;
  logic [3:0]  win;

  assign mask_ext  = 16'(mask);
  assign start_ext = 4'(start);
  assign win       = rr_winner(mask_ext, start_ext, NUM_CHN);
  assign valid     = |mask;
  assign idx       = IDX_W'(win);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_CHN; i++) begin
      onehot[i] = valid && (win == 4'(i));
    end
  end

endmodule

// File: rtl/mcntrl_refresh_arbiter.sv
// Arbiter between DRAM refresh and NUM_CHN data channels, driving one command sequencer.
module mcntrl_refresh_arbiter
  import mcntrl_pkg::*;
#(
  parameter int NUM_CHN        = 4,
  parameter int RFC_CYCLES     = 64,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int IDX_W          = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1
) (
  input  logic               clk,
  input  logic               mrst_n,
  input  logic               en,
  input  logic               refresh_want,
  input  logic               refresh_need,
  output logic               refresh_grant,
  input  logic [NUM_CHN-1:0] ch_want,
  input  logic [NUM_CHN-1:0] ch_need,
  output logic [NUM_CHN-1:0] ch_grant,
  output logic [IDX_W-1:0]   grant_chn,
  output logic               seq_start,
  output logic               seq_refresh,
  input  logic               seq_done,
  output logic               busy,
  output logic               timeout_err
);

  arb_state_e         state_q, state_d;
  logic               sel_refresh_q, sel_refresh_d;
  logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;
  logic [7:0]         rfc_cnt_q, rfc_cnt_d;
  logic [15:0]        tmo_cnt_q, tmo_cnt_d;
  logic               timeout_err_q, timeout_err_d;
  logic               refresh_grant_q, refresh_grant_d;
  logic [NUM_CHN-1:0] ch_grant_q, ch_grant_d;
  logic               seq_start_q, seq_start_d;
  logic               seq_refresh_q, seq_refresh_d;
  logic [IDX_W-1:0]   grant_chn_q, grant_chn_d;

  logic [IDX_W-1:0]   rr_start;
  logic               need_vld, want_vld;
  logic [IDX_W-1:0]   need_idx, want_idx;
  logic [NUM_CHN-1:0] need_oh, want_oh;

  assign rr_start = (grant_chn_q == IDX_W'(NUM_CHN - 1)) ? '0 : grant_chn_q + IDX_W'(1);

  mcntrl_rr_select #(.NUM_CHN(NUM_CHN), .IDX_W(IDX_W)) u_rr_need (
    .mask   (ch_want & ch_need),
    .start  (rr_start),
    .valid  (need_vld),
    .idx    (need_idx),
    .onehot (need_oh)
  );

  mcntrl_rr_select #(.NUM_CHN(NUM_CHN), .IDX_W(IDX_W)) u_rr_want (
    .mask   (ch_want),
    .start  (rr_start),
    .valid  (want_vld),
    .idx    (want_idx),
    .onehot (want_oh)
  );

  always_comb begin
    state_d         = state_q;
    sel_refresh_d   = sel_refresh_q;
    sel_idx_d       = sel_idx_q;
    rfc_cnt_d       = rfc_cnt_q;
    tmo_cnt_d       = tmo_cnt_q;
    timeout_err_d   = timeout_err_q;
    refresh_grant_d = 1'b0;
    ch_grant_d      = '0;
    seq_start_d     = 1'b0;
    seq_refresh_d   = 1'b0;
    grant_chn_d     = grant_chn_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          if (refresh_need) begin
            state_d       = ST_GRANT;
            sel_refresh_d = 1'b1;
          end else if (need_vld) begin
            state_d       = ST_GRANT;
            sel_refresh_d = 1'b0;
            sel_idx_d     = need_idx;
          end else if (want_vld) begin
            state_d       = ST_GRANT;
            sel_refresh_d = 1'b0;
            sel_idx_d     = want_idx;
          end else if (refresh_want) begin
            state_d       = ST_GRANT;
            sel_refresh_d = 1'b1;
          end
        end
      end
      // Grant outputs are registered here so they pulse in the first WAIT_DONE cycle.
      ST_GRANT: begin
        tmo_cnt_d       = '0;
        seq_start_d     = 1'b1;
        seq_refresh_d   = sel_refresh_q;
        refresh_grant_d = sel_refresh_q;
        if (!sel_refresh_q) begin
          grant_chn_d = sel_idx_q;
          for (int i = 0; i < NUM_CHN; i++) begin
            ch_grant_d[i] = (sel_idx_q == IDX_W'(i));
          end
        end
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (seq_done) begin
          if (sel_refresh_q) begin
            state_d   = ST_RFC_GAP;
            rfc_cnt_d = 8'(RFC_CYCLES - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      ST_RFC_GAP: begin
        if (rfc_cnt_q == 8'd0) state_d = ST_IDLE;
        else                   rfc_cnt_d = rfc_cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge mrst_n) begin
    if (!mrst_n) begin
      state_q         <= ST_IDLE;
      sel_refresh_q   <= 1'b0;
      sel_idx_q       <= '0;
      rfc_cnt_q       <= '0;
      tmo_cnt_q       <= '0;
      timeout_err_q   <= 1'b0;
      refresh_grant_q <= 1'b0;
      ch_grant_q      <= '0;
      seq_start_q     <= 1'b0;
      seq_refresh_q   <= 1'b0;
      grant_chn_q     <= IDX_W'(NUM_CHN - 1);
    end else begin
      state_q         <= state_d;
      sel_refresh_q   <= sel_refresh_d;
      sel_idx_q       <= sel_idx_d;
      rfc_cnt_q       <= rfc_cnt_d;
      tmo_cnt_q       <= tmo_cnt_d;
      timeout_err_q   <= timeout_err_d;
      refresh_grant_q <= refresh_grant_d;
      ch_grant_q      <= ch_grant_d;
      seq_start_q     <= seq_start_d;
      seq_refresh_q   <= seq_refresh_d;
      grant_chn_q     <= grant_chn_d;
    end
  end

  assign refresh_grant = refresh_grant_q;
  assign ch_grant      = ch_grant_q;
  assign seq_start     = seq_start_q;
  assign seq_refresh   = seq_refresh_q;
  assign grant_chn     = grant_chn_q;
  assign timeout_err   = timeout_err_q;
  assign busy          = (state_q != ST_IDLE);

  logic unused_oh;
  assign unused_oh = ^{need_oh, want_oh};

endmodule

// File: tb/tb_mcntrl_refresh_arbiter.sv
// Directed bench for mcntrl_refresh_arbiter with hand-computed expectations.
module tb_mcntrl_refresh_arbiter;

  logic       clk = 1'b0;
  logic       mrst_n;
  logic       en;
  logic       refresh_want, refresh_need, refresh_grant;
  logic [3:0] ch_want, ch_need, ch_grant;
  logic [1:0] grant_chn;
  logic       seq_start, seq_refresh, seq_done, busy, timeout_err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mcntrl_refresh_arbiter #(
    .NUM_CHN(4), .RFC_CYCLES(64), .TIMEOUT_CYCLES(15)
  ) dut (
    .clk(clk), .mrst_n(mrst_n), .en(en),
    .refresh_want(refresh_want), .refresh_need(refresh_need), .refresh_grant(refresh_grant),
    .ch_want(ch_want), .ch_need(ch_need), .ch_grant(ch_grant), .grant_chn(grant_chn),
    .seq_start(seq_start), .seq_refresh(seq_refresh), .seq_done(seq_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the next grant pulse and check what was granted.
  task automatic wait_grant(input string tag, input logic [3:0] exp_oh,
                            input logic [1:0] exp_idx, input logic exp_ref);
    int n;
    n = 0;
    while (!seq_start && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_start"}, 32'(seq_start), 32'd1);
    check({tag, "_grant"}, 32'({refresh_grant, seq_refresh, ch_grant}),
          32'({exp_ref, exp_ref, exp_oh}));
    check({tag, "_chn"}, 32'(grant_chn), 32'(exp_idx));
  endtask

  task automatic finish_op();
    tick();
    tick();
    seq_done = 1'b1;
    tick();
    seq_done = 1'b0;
  endtask

  task automatic count_busy(output int len);
    len = 0;
    while (busy && len < 300) begin
      tick();
      len++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int len;
    int stray;
    mrst_n = 1'b0; en = 1'b1; refresh_want = 1'b0; refresh_need = 1'b0;
    ch_want = '0; ch_need = '0; seq_done = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(seq_start), 32'd0);
    check("rst_chn", 32'(grant_chn), 32'd3);
    check("rst_err", 32'(timeout_err), 32'd0);
    mrst_n = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);

    // Idle refresh: grant two edges after the request, then 64 gap cycles.
    refresh_want = 1'b1;
    tick();
    check("rf_lat1_start", 32'(seq_start), 32'd0);
    check("rf_lat1_busy", 32'(busy), 32'd1);
    tick();
    check("rf_lat2_grant", 32'({refresh_grant, seq_refresh, seq_start, ch_grant}), 32'h70);
    refresh_want = 1'b0;
    tick();
    check("rf_no_back2back", 32'(seq_start), 32'd0);
    seq_done = 1'b1;
    tick();
    seq_done = 1'b0;
    count_busy(len);
    check("rf_gap_len", 32'(len), 32'd64);

    // Round robin over ch_want = 1011 starting after channel 3.
    ch_want = 4'b1011;
    wait_grant("rr0", 4'b0001, 2'd0, 1'b0); finish_op();
    wait_grant("rr1", 4'b0010, 2'd1, 1'b0); finish_op();
    wait_grant("rr3", 4'b1000, 2'd3, 1'b0); finish_op();
    wait_grant("rr0b", 4'b0001, 2'd0, 1'b0);
    ch_want = 4'b0000;
    finish_op();

    // Priority: need class, then want class, then deferrable refresh.
    ch_want = 4'b0110; ch_need = 4'b0100; refresh_want = 1'b1;
    wait_grant("pr_ch2", 4'b0100, 2'd2, 1'b0);
    ch_want = 4'b0010; ch_need = 4'b0000;
    finish_op();
    wait_grant("pr_ch1", 4'b0010, 2'd1, 1'b0);
    ch_want = 4'b0000;
    finish_op();
    wait_grant("pr_rfw", 4'b0000, 2'd1, 1'b1);
    refresh_want = 1'b0;
    finish_op();

    // refresh_need raised during ch2's WAIT_DONE overtakes the waiting ch1.
    ch_want = 4'b0110; ch_need = 4'b0100;
    wait_grant("rn_ch2", 4'b0100, 2'd2, 1'b0);
    refresh_need = 1'b1; ch_want = 4'b0010; ch_need = 4'b0000;
    finish_op();
    wait_grant("rn_ref", 4'b0000, 2'd2, 1'b1);
    refresh_need = 1'b0;
    finish_op();
    wait_grant("rn_ch1", 4'b0010, 2'd1, 1'b0);
    ch_want = 4'b0000;
    finish_op();

    // Simultaneous refresh_need and ch_need: refresh first, channel next.
    ch_want = 4'b1000; ch_need = 4'b1000; refresh_need = 1'b1;
    wait_grant("sim_ref", 4'b0000, 2'd1, 1'b1);
    refresh_need = 1'b0;
    finish_op();
    wait_grant("sim_ch3", 4'b1000, 2'd3, 1'b0);
    ch_want = 4'b0000; ch_need = 4'b0000;
    finish_op();

    // Timeout: ch0 granted, no seq_done.
    ch_want = 4'b0001;
    wait_grant("to_ch0", 4'b0001, 2'd0, 1'b0);
    ch_want = 4'b0000;
    check("to_err_before", 32'(timeout_err), 32'd0);
    count_busy(len);
    check("to_wait_len", 32'(len), 32'd15);
    check("to_err_set", 32'(timeout_err), 32'd1);
    seq_done = 1'b1;
    tick();
    seq_done = 1'b0;
    tick();
    check("to_late_done_busy", 32'(busy), 32'd0);
    check("to_late_done_start", 32'(seq_start), 32'd0);
    check("to_err_sticky", 32'(timeout_err), 32'd1);

    // Enable drop during a refresh's WAIT_DONE.
    refresh_want = 1'b1;
    wait_grant("en_ref", 4'b0000, 2'd0, 1'b1);
    refresh_want = 1'b0; en = 1'b0; ch_want = 4'hF;
    finish_op();
    count_busy(len);
    check("en_gap_len", 32'(len), 32'd64);
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      if (seq_start || busy) stray++;
      tick();
    end
    check("en_parked", 32'(stray), 32'd0);
    en = 1'b1;
    wait_grant("en_resume", 4'b0010, 2'd1, 1'b0);
    ch_want = 4'b0000;
    finish_op();

    // Asynchronous reset while in RFC_GAP.
    refresh_want = 1'b1;
    wait_grant("ar_ref", 4'b0000, 2'd1, 1'b1);
    refresh_want = 1'b0;
    finish_op();
    repeat (5) tick();
    check("ar_busy_before", 32'(busy), 32'd1);
    #3;
    mrst_n = 1'b0;
    ch_want = 4'hF;
    #1;
    check("ar_busy_async", 32'(busy), 32'd0);
    check("ar_chn_async", 32'(grant_chn), 32'd3);
    check("ar_err_clr", 32'(timeout_err), 32'd0);
    tick();
    tick();
    mrst_n = 1'b1;
    tick();
    check("ar_no_grant_first", 32'(seq_start), 32'd0);
    tick();
    check("ar_grant_ch0", 32'({seq_start, ch_grant}), 32'h11);
    ch_want = 4'b0000;
    finish_op();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mcntrl_refresh_arbiter.md
MCNTRL_REFRESH_ARBITER -- requirements
Module: mcntrl_refresh_arbiter

Interface
REQ-001 Parameter NUM_CHN, default 4: number of data-channel requesters, range 2..16.
REQ-002 Parameter RFC_CYCLES, default 64: idle cycles enforced after a refresh completes (tRFC), range 1..255.
REQ-003 Parameter TIMEOUT_CYCLES, default 1023: maximum cycles from grant to seq_done, range 15..65535.
REQ-004 Ports:
- clk  in  1: single clock, rising edge.
- mrst_n  in  1: reset, asynchronous assert, active-low.
- en  in  1: arbiter enable; 0 blocks new grants.
- refresh_want  in  1: refresh pending, deferrable.
- refresh_need  in  1: refresh backlog urgent.
- refresh_grant  out  1: one-cycle pulse, refresh granted.
- ch_want  in  NUM_CHN: channel requests.
- ch_need  in  NUM_CHN: urgent channel requests; valid only with the matching ch_want bit.
- ch_grant  out  NUM_CHN: one-hot, one-cycle grant pulse.
- grant_chn  out  clog2(NUM_CHN): index of the last channel granted; held until the next channel grant.
- seq_start  out  1: one-cycle pulse to the command sequencer, coincident with any grant.
- seq_refresh  out  1: qualifies seq_start; 1 = refresh, 0 = channel access.
- seq_done  in  1: one-cycle pulse, sequencer finished.
- busy  out  1: arbiter not in IDLE.
- timeout_err  out  1: sticky flag, sequencer timeout seen; cleared only by reset.

Function
REQ-005 States SHALL be IDLE, GRANT, WAIT_DONE and RFC_GAP, state-encoded, with IDLE as the reset state.
REQ-006 In IDLE with en=1, the highest-priority eligible request SHALL move the FSM to GRANT on the next edge; with no eligible request the FSM SHALL stay in IDLE.
REQ-007 Priority SHALL be, highest first:
- refresh_need
- any channel with ch_want&ch_need
- any ch_want
- refresh_want
REQ-008 Within a channel priority class, selection SHALL be round-robin: search starts at (last granted index + 1) mod NUM_CHN. The pointer SHALL update only on a channel grant.
REQ-009 The GRANT state SHALL last exactly one cycle and SHALL assert seq_start together with either refresh_grant or the one-hot ch_grant bit.
- seq_refresh SHALL be valid in the same cycle.
- The next state SHALL be WAIT_DONE.
REQ-010 The request latency SHALL be 2 cycles: a request sampled in IDLE at edge N produces its grant pulse in the cycle after edge N+1.
REQ-011 The selection SHALL be registered at the IDLE->GRANT edge. Request changes during GRANT or WAIT_DONE SHALL NOT alter the in-flight grant.
REQ-012 In WAIT_DONE, seq_done SHALL cause the next state to be RFC_GAP for a refresh grant and IDLE for a channel grant.
REQ-013 RFC_GAP SHALL last exactly RFC_CYCLES cycles, counted by a down-counter loaded on entry, and SHALL then go to IDLE. No grants SHALL be issued during RFC_GAP.
REQ-014 A timeout counter SHALL be cleared in GRANT and incremented in WAIT_DONE. Reaching TIMEOUT_CYCLES without seq_done SHALL set timeout_err and return the FSM to IDLE, skipping RFC_GAP.
REQ-015 seq_done outside WAIT_DONE SHALL be ignored.
REQ-016 Deasserting en SHALL NOT abort GRANT, WAIT_DONE or RFC_GAP; the operation in flight SHALL complete and the FSM SHALL then park in IDLE.
REQ-017 If refresh_need and ch_need rise in the same cycle, refresh SHALL win. The channel SHALL be served next if it is still requesting.
REQ-018 The arbiter SHALL never issue two grant pulses in consecutive cycles. At most one grant bit SHALL be active per cycle.
REQ-019 busy SHALL be 1 in GRANT, WAIT_DONE and RFC_GAP, and 0 in IDLE.

Reset
REQ-020 mrst_n=0 SHALL asynchronously drive:
- FSM to IDLE
- refresh_grant, ch_grant, seq_start, seq_refresh, busy and timeout_err to 0
- grant_chn to NUM_CHN-1, so the first round-robin search starts at channel 0
- all counters to 0
REQ-021 Reset asserted mid-operation SHALL drop any grant pulse in the same cycle and SHALL lose the in-flight operation without a recorded error.
REQ-022 Reset deassertion SHALL be synchronized externally. The block SHALL issue no grant in the first cycle after release.

Structure
REQ-023 The FSM state encoding, and a function returning the round-robin winner index for a mask and a start pointer, SHALL live in the shared mcntrl_pkg package.
REQ-024 The round-robin selector SHALL be one sub-module, mcntrl_rr_select: inputs are the mask and the start pointer; outputs are valid, index and one-hot. It is instantiated twice, once for the need class and once for the want class.

Verification
REQ-025 Idle refresh: refresh_want=1 only, RFC_CYCLES=64 -> refresh_grant and seq_start with seq_refresh=1 two cycles later. After seq_done, busy stays 1 for 64 cycles, then IDLE.
REQ-026 Round-robin: ch_want=4'b1011 held, seq_done 3 cycles after each grant -> grants in the order ch0, ch1, ch3, ch0; grant_chn follows.
REQ-027 Priority: ch_want=4'b0110 with ch_need[2]=1 and refresh_want=1 -> ch2 first, ch1 next, refresh_want last. Raising refresh_need during ch2's WAIT_DONE -> refresh is granted right after ch2 completes.
REQ-028 Timeout: TIMEOUT_CYCLES=15, grant ch0, no seq_done -> after 15 WAIT_DONE cycles timeout_err=1, FSM in IDLE. A late seq_done is ignored.
REQ-029 Enable drop: en=0 during a refresh's WAIT_DONE -> seq_done accepted, RFC_GAP completes, no further grants while en=0 with ch_want=4'hF.
REQ-030 Async reset in RFC_GAP -> busy=0 immediately, before the next edge. No grant until requests are re-sampled after release.
